// File: rtl/rs232_in_arbiter.sv
// Round-robin arbiter moving finished packets from two RS-232 capture channels
// into the shared USB IN endpoint buffer: header byte, payload, commit, wait for ack.
module rs232_in_arbiter #(
  parameter logic [15:0] ACK_TIMEOUT = 16'hFFFF,
  parameter logic [7:0]  HDR_BASE    = 8'hA0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [8:0] len0,
  input  logic [8:0] len1,
  output logic       rd0,
  output logic       rd1,
  input  logic [7:0] dat0,
  input  logic [7:0] dat1,
  output logic       done0,
  output logic       done1,
  output logic       err0,
  output logic       err1,
  output logic [8:0] buf_in_addr,
  output logic [7:0] buf_in_data,
  output logic       buf_in_wren,
  input  logic       buf_in_ready,
  output logic       buf_in_commit,
  output logic [9:0] buf_in_commit_len,
  input  logic       buf_in_commit_ack
);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_RDY, S_HDR, S_WR, S_WRX, S_RD, S_LAT, S_CAP, S_COMMIT, S_WAIT_ACK
  } state_t;

  // Bit 0: endpoint ready, bit 1: commit acknowledge; both arrive asynchronously.
  logic [1:0] async_in;
  logic [1:0] sync_s;
  assign async_in = {buf_in_commit_ack, buf_in_ready};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sync_s[gi] = sync_reg;
    end
  endgenerate

  logic ready_s, ack_s, ack_d_reg, ack_rise;
  assign ready_s  = sync_s[0];
  assign ack_s    = sync_s[1];
  assign ack_rise = ack_s & ~ack_d_reg;

  state_t      state_reg, state_next;
  logic        chan_reg, chan_next;
  logic        last_reg, last_next;
  logic [8:0]  len_reg, len_next;
  logic [8:0]  rem_reg, rem_next;
  logic [15:0] tcnt_reg, tcnt_next;
  logic [8:0]  addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        wren_reg, wren_next;
  logic        commit_reg, commit_next;
  logic [9:0]  commit_len_reg, commit_len_next;
  logic [1:0]  rd_reg, rd_next;
  logic [1:0]  done_reg, done_next;
  logic [1:0]  err_reg, err_next;

  // On a tie the channel that was not served last wins.
  logic gnt0;
  assign gnt0 = req0 & (~req1 | last_reg);

  always_comb begin
    state_next      = state_reg;
    chan_next       = chan_reg;
    last_next       = last_reg;
    len_next        = len_reg;
    rem_next        = rem_reg;
    tcnt_next       = tcnt_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    wren_next       = 1'b0;
    commit_next     = 1'b0;
    commit_len_next = commit_len_reg;
    rd_next         = 2'b00;
    done_next       = 2'b00;
    err_next        = 2'b00;
    case (state_reg)
      S_IDLE: begin
        if (req0 | req1) begin
          chan_next  = ~gnt0;
          last_next  = ~gnt0;
          len_next   = gnt0 ? len0 : len1;
          rem_next   = gnt0 ? len0 : len1;
          state_next = S_WAIT_RDY;
        end
      end
      S_WAIT_RDY: if (ready_s) state_next = S_HDR;
      S_HDR: begin
        addr_next  = 9'd0;
        data_next  = HDR_BASE | {7'd0, chan_reg};
        state_next = S_WR;
      end
      S_WR: begin
        wren_next  = 1'b1;
        state_next = S_WRX;
      end
      S_WRX: state_next = (rem_reg == 9'd0) ? S_COMMIT : S_RD;
      S_RD: begin
        rd_next[chan_reg] = 1'b1;
        state_next        = S_LAT;
      end
      S_LAT: state_next = S_CAP;
      S_CAP: begin
        data_next  = chan_reg ? dat1 : dat0;
        addr_next  = addr_reg + 9'd1;
        rem_next   = rem_reg - 9'd1;
        state_next = S_WR;
      end
      S_COMMIT: begin
        commit_next     = 1'b1;
        commit_len_next = {1'b0, len_reg} + 10'd1;
        tcnt_next       = 16'd0;
        state_next      = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // Ack is tested first so it wins over a simultaneous timeout.
        if (ack_rise) begin
          done_next[chan_reg] = 1'b1;
          state_next          = S_IDLE;
        end else if (tcnt_reg == ACK_TIMEOUT - 16'd1) begin
          err_next[chan_reg] = 1'b1;
          state_next         = S_IDLE;
        end else begin
          tcnt_next = tcnt_reg + 16'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      chan_reg       <= 1'b0;
      last_reg       <= 1'b1;
      len_reg        <= 9'd0;
      rem_reg        <= 9'd0;
      tcnt_reg       <= 16'd0;
      addr_reg       <= 9'd0;
      data_reg       <= 8'd0;
      wren_reg       <= 1'b0;
      commit_reg     <= 1'b0;
      commit_len_reg <= 10'd0;
      rd_reg         <= 2'b00;
      done_reg       <= 2'b00;
      err_reg        <= 2'b00;
      ack_d_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      chan_reg       <= chan_next;
      last_reg       <= last_next;
      len_reg        <= len_next;
      rem_reg        <= rem_next;
      tcnt_reg       <= tcnt_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      wren_reg       <= wren_next;
      commit_reg     <= commit_next;
      commit_len_reg <= commit_len_next;
      rd_reg         <= rd_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      ack_d_reg      <= ack_s;
    end
  end

  assign rd0               = rd_reg[0];
  assign rd1               = rd_reg[1];
  assign done0             = done_reg[0];
  assign done1             = done_reg[1];
  assign err0              = err_reg[0];
  assign err1              = err_reg[1];
  assign buf_in_addr       = addr_reg;
  assign buf_in_data       = data_reg;
  assign buf_in_wren       = wren_reg;
  assign buf_in_commit     = commit_reg;
  assign buf_in_commit_len = commit_len_reg;

endmodule

// File: tb/tb_rs232_in_arbiter.sv
// Bench for rs232_in_arbiter: channel and ack responders, a bus monitor, and a
// packet-level model of the expected endpoint writes, commits and grant order.
module tb_rs232_in_arbiter;
  localparam int TMO = 20;
  localparam logic [7:0] HDR = 8'hA0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [8:0] len0 = '0, len1 = '0;
  logic       rd0, rd1;
  logic [7:0] dat0 = '0, dat1 = '0;
  logic       done0, done1, err0, err1;
  logic [8:0] buf_in_addr;
  logic [7:0] buf_in_data;
  logic       buf_in_wren;
  logic       buf_in_ready = 1'b1;
  logic       buf_in_commit;
  logic [9:0] buf_in_commit_len;
  logic       buf_in_commit_ack = 1'b0;

  rs232_in_arbiter #(.ACK_TIMEOUT(16'(TMO)), .HDR_BASE(HDR)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1),
    .rd0(rd0), .rd1(rd1), .dat0(dat0), .dat1(dat1),
    .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .buf_in_addr(buf_in_addr), .buf_in_data(buf_in_data), .buf_in_wren(buf_in_wren),
    .buf_in_ready(buf_in_ready), .buf_in_commit(buf_in_commit),
    .buf_in_commit_len(buf_in_commit_len), .buf_in_commit_ack(buf_in_commit_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: everything the DUT does, logged on the falling edge
  logic [16:0] wq[$];
  int          wcyc[$];
  int          rd_cnt[2] = '{0, 0};
  int          done_cnt[2] = '{0, 0};
  int          err_cnt[2] = '{0, 0};
  int          commit_cnt = 0, commit_cyc = 0, err_cyc = 0, wren_long = 0, rd_both = 0;
  logic [9:0]  commit_len_seen = '0;
  logic        wren_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (buf_in_wren === 1'b1) begin
        wq.push_back({buf_in_addr, buf_in_data});
        wcyc.push_back(cyc);
        if (wren_prev) wren_long++;
      end
      wren_prev = (buf_in_wren === 1'b1);
      if (rd0 === 1'b1) rd_cnt[0]++;
      if (rd1 === 1'b1) rd_cnt[1]++;
      if (rd0 === 1'b1 && rd1 === 1'b1) rd_both++;
      if (buf_in_commit === 1'b1) begin
        commit_cnt++;
        commit_cyc = cyc;
        commit_len_seen = buf_in_commit_len;
      end
      if (done0 === 1'b1) done_cnt[0]++;
      if (done1 === 1'b1) done_cnt[1]++;
      if (err0 === 1'b1) begin err_cnt[0]++; err_cyc = cyc; end
      if (err1 === 1'b1) begin err_cnt[1]++; err_cyc = cyc; end
    end
  end

  // Channel side: data is valid only in the cycle following a read strobe
  logic [7:0] pay [2][512];

  task automatic respond(input int ch);
    int   k = 0;
    logic strobe, clr;
    forever begin
      @(negedge clk);
      strobe = (ch == 0) ? (rd0 === 1'b1) : (rd1 === 1'b1);
      clr = reset || ((ch == 0) ? (done0 === 1'b1 || err0 === 1'b1 || !req0)
                                : (done1 === 1'b1 || err1 === 1'b1 || !req1));
      @(posedge clk);
      #1;
      if (clr) k = 0;
      if (strobe) begin
        if (ch == 0) dat0 = pay[0][k % 512]; else dat1 = pay[1][k % 512];
        k++;
      end else begin
        if (ch == 0) dat0 = 8'($urandom); else dat1 = 8'($urandom);
      end
    end
  endtask

  initial respond(0);
  initial respond(1);

  // Endpoint side: acknowledge a commit after ack_dly cycles unless disabled
  bit ack_on = 1'b1;
  int ack_dly = 3;
  initial begin
    forever begin
      @(negedge clk);
      if (buf_in_commit === 1'b1 && ack_on) begin
        repeat (ack_dly) @(negedge clk);
        buf_in_commit_ack = 1'b1;
        for (int i = 0; i < 40 && !(done0 | done1 | err0 | err1 | reset); i++) @(negedge clk);
        buf_in_commit_ack = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int checks = 0, errors = 0;
  int model_last = 1;
  int s_wb, s_cb;
  int s_rd[2], s_done[2], s_err[2];
  bit fin;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: a lone request wins; a tie goes to the channel not served last.
  function automatic int model_grant(input bit r0, input bit r1);
    if (r0 && r1) return (model_last == 0) ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  task automatic snap();
    s_wb = wq.size();
    s_cb = commit_cnt;
    for (int c = 0; c < 2; c++) begin
      s_rd[c] = rd_cnt[c]; s_done[c] = done_cnt[c]; s_err[c] = err_cnt[c];
    end
  endtask

  task automatic fill(input int ch);
    for (int i = 0; i < 512; i++) pay[ch][i] = 8'($urandom);
  endtask

  task automatic set_req(input int ch, input bit v, input int ln);
    if (ch == 0) begin req0 = v; len0 = 9'(ln); end
    else begin req1 = v; len1 = 9'(ln); end
  endtask

  task automatic wait_end(input int ch, input int bound);
    fin = 1'b0;
    for (int n = 0; n < bound && !fin; n++) begin
      @(negedge clk); #1;
      if (done_cnt[ch] != s_done[ch] || err_cnt[ch] != s_err[ch]) fin = 1'b1;
    end
    chk("pkt_finish", 64'(fin), 64'd1);
  endtask

  // Expected packet: header HDR|ch at addr 0, then the channel's bytes at 1..len
  task automatic verify(input int ch, input int ln, input bit acked);
    int         o, nw;
    logic [7:0] e;
    o  = 1 - ch;
    nw = wq.size() - s_wb;
    chk("write_count", 64'(nw), 64'(ln + 1));
    for (int i = 0; i < nw && i <= ln; i++) begin
      e = (i == 0) ? (HDR | 8'(ch)) : pay[ch][i - 1];
      chk($sformatf("wr_addr[%0d]", i), 64'(wq[s_wb + i][16:8]), 64'(i));
      chk($sformatf("wr_data[%0d]", i), 64'(wq[s_wb + i][7:0]), 64'(e));
    end
    chk("commit_count", 64'(commit_cnt - s_cb), 64'd1);
    chk("commit_len", 64'(commit_len_seen), 64'(ln + 1));
    chk("rd_granted", 64'(rd_cnt[ch] - s_rd[ch]), 64'(ln));
    chk("rd_other", 64'(rd_cnt[o] - s_rd[o]), 64'd0);
    chk("done", 64'(done_cnt[ch] - s_done[ch]), 64'(acked));
    chk("err", 64'(err_cnt[ch] - s_err[ch]), 64'(!acked));
    chk("done_other", 64'(done_cnt[o] - s_done[o]), 64'd0);
    chk("err_other", 64'(err_cnt[o] - s_err[o]), 64'd0);
    $display("pkt ch=%0d len=%0d writes=%0d commit_len=%0d %s", ch, ln, nw,
             commit_len_seen, acked ? "done" : "timeout");
    model_last = ch;
  endtask

  task automatic run_pkt(input int ch, input int ln, input bit acked, input bit timed,
                         input int dly, input bit other);
    int start;
    snap();
    ack_on = acked;
    ack_dly = dly;
    @(negedge clk); #1;
    start = cyc;
    set_req(ch, 1'b1, ln);
    if (other) set_req(1 - ch, 1'b1, 2);
    wait_end(ch, 5 * ln + 100);
    set_req(ch, 1'b0, ln);
    verify(ch, ln, acked);
    if (timed && wq.size() > s_wb) begin
      chk("hdr_wren_time", 64'(wcyc[s_wb] - start), 64'd4);
      chk("commit_time", 64'((commit_cyc - start >= 6 + 5 * ln) &&
                             (commit_cyc - start <= 7 + 5 * ln)), 64'd1);
    end
    if (!acked) chk("timeout_cycles", 64'(err_cyc - commit_cyc), 64'(TMO));
  endtask

  initial begin
    int g, ready_cyc, ln;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_ctl", 64'({rd0, rd1, done0, done1, err0, err1, buf_in_wren, buf_in_commit}), 64'd0);
    chk("reset_bus", 64'({buf_in_addr, buf_in_data, buf_in_commit_len}), 64'd0);
    #1; reset = 1'b0;
    repeat (3) @(negedge clk);

    // Channel 0, three known bytes, ack five cycles after commit
    fill(0);
    pay[0][0] = 8'h11; pay[0][1] = 8'h22; pay[0][2] = 8'h33;
    run_pkt(0, 3, 1'b1, 1'b1, 5, 1'b0);

    // Empty packet on channel 1: header only
    run_pkt(1, 0, 1'b1, 1'b1, 3, 1'b0);

    // Both channels requesting continuously, four packets of one byte
    fill(0); fill(1);
    snap();
    ack_on = 1'b1; ack_dly = 2;
    @(negedge clk); #1;
    len0 = 9'd1; len1 = 9'd1; req0 = 1'b1; req1 = 1'b1;
    fin = 1'b0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clk); #1;
      if (done_cnt[0] + done_cnt[1] - s_done[0] - s_done[1] >= 4) fin = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_finish", 64'(fin), 64'd1);
    chk("rr_write_count", 64'(wq.size() - s_wb), 64'd8);
    for (int p = 0; p < 4; p++) begin
      if (s_wb + 2 * p + 1 < wq.size()) begin
        g = model_grant(1'b1, 1'b1);
        model_last = g;
        chk($sformatf("rr_hdr[%0d]", p), 64'(wq[s_wb + 2 * p]), 64'({9'd0, HDR | 8'(g)}));
        chk($sformatf("rr_byte[%0d]", p), 64'(wq[s_wb + 2 * p + 1]), 64'({9'd1, pay[g][0]}));
        $display("rr pkt %0d ch=%0d hdr=%0h", p, g, wq[s_wb + 2 * p][7:0]);
      end
    end
    chk("rr_done0", 64'(done_cnt[0] - s_done[0]), 64'd2);
    chk("rr_done1", 64'(done_cnt[1] - s_done[1]), 64'd2);

    // Ack never returned on channel 0 while channel 1 waits; channel 1 follows the error
    fill(0); fill(1);
    run_pkt(0, 2, 1'b0, 1'b1, 0, 1'b1);
    run_pkt(1, 2, 1'b1, 1'b0, 4, 1'b0);
    if (wq.size() > s_wb) chk("rr_after_err", 64'(wcyc[s_wb] - err_cyc), 64'd4);

    // Random single-channel packets
    for (int r = 0; r < 5; r++) begin
      g = $urandom_range(0, 1);
      fill(g);
      run_pkt(g, $urandom_range(0, 40), 1'b1, 1'b1, $urandom_range(1, 10), 1'b0);
    end

    // Largest packet
    fill(0);
    run_pkt(0, 511, 1'b1, 1'b1, 7, 1'b0);

    // Endpoint not ready for 50 cycles
    @(negedge clk); #1;
    buf_in_ready = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    fill(0);
    snap();
    ack_on = 1'b1; ack_dly = 3;
    set_req(0, 1'b1, 2);
    repeat (50) @(negedge clk);
    #1;
    chk("rdy_no_write", 64'(wq.size() - s_wb), 64'd0);
    chk("rdy_no_rd", 64'(rd_cnt[0] + rd_cnt[1] - s_rd[0] - s_rd[1]), 64'd0);
    ready_cyc = cyc;
    buf_in_ready = 1'b1;
    wait_end(0, 200);
    set_req(0, 1'b0, 2);
    verify(0, 2, 1'b1);
    if (wq.size() > s_wb)
      chk("rdy_first_write", 64'((wcyc[s_wb] - ready_cyc >= 3) && (wcyc[s_wb] - ready_cyc <= 6)), 64'd1);

    // Reset during the second payload byte of a five-byte packet
    fill(0);
    snap();
    ack_on = 1'b1;
    @(negedge clk); #1;
    set_req(0, 1'b1, 5);
    fin = 1'b0;
    for (int n = 0; n < 200 && !fin; n++) begin
      @(negedge clk); #1;
      if (rd_cnt[0] - s_rd[0] >= 2) fin = 1'b1;
    end
    chk("rst_reach_byte2", 64'(fin), 64'd1);
    reset = 1'b1;
    set_req(0, 1'b0, 5);
    @(negedge clk); #1;
    reset = 1'b0;
    chk("rst_ctl", 64'({rd0, rd1, done0, done1, err0, err1, buf_in_wren, buf_in_commit}), 64'd0);
    chk("rst_bus", 64'({buf_in_addr, buf_in_data, buf_in_commit_len}), 64'd0);
    model_last = 1;
    repeat (30) @(negedge clk);
    #1;
    chk("rst_no_commit", 64'(commit_cnt - s_cb), 64'd0);
    chk("rst_no_done", 64'(done_cnt[0] - s_done[0]), 64'd0);
    chk("rst_no_err", 64'(err_cnt[0] - s_err[0]), 64'd0);
    $display("reset mid-packet: outputs cleared, no commit");

    // Normal service after the reset
    ln = $urandom_range(1, 20);
    fill(1);
    run_pkt(1, ln, 1'b1, 1'b1, 2, 1'b0);

    chk("wren_single_cycle", 64'(wren_long), 64'd0);
    chk("rd_exclusive", 64'(rd_both), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_in_arbiter.md
# rs232_in_arbiter

Arbitrates two RS-232 capture channels (A/B pair and C/D pair) onto the single USB IN endpoint buffer. It sequences header and payload writes, then issues the commit and waits for its acknowledgement. Each capture channel presents a finished packet through a request/length/read-strobe interface. This block alone drives `buf_in_*`, so one endpoint is shared fairly between the channels.

## Interface
Parameters:
- `ACK_TIMEOUT`, 16'hFFFF: cycles to wait for a synchronised commit ack before abandoning the packet.
- `HDR_BASE`, 8'hA0: header byte base; the header sent is `HDR_BASE | chan`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high reset.
- `req0`, `req1` in 1: the channel has a complete packet ready; held until `doneN` or `errN`.
- `len0`, `len1` in 9: payload byte count, 0..511; stable while `reqN` is high.
- `rd0`, `rd1` out 1: one-cycle read strobe; `datN` is valid on the cycle after the strobe.
- `dat0`, `dat1` in 8: payload byte from the channel.
- `done0`, `done1` out 1: one-cycle pulse when the packet is committed and acknowledged.
- `err0`, `err1` out 1: one-cycle pulse on ack timeout.
- `buf_in_addr` out 9: endpoint buffer address.
- `buf_in_data` out 8: endpoint buffer write data.
- `buf_in_wren` out 1: endpoint buffer write enable.
- `buf_in_ready` in 1: endpoint buffer free; asynchronous, 2-flop synchronised internally.
- `buf_in_commit` out 1: one-cycle commit pulse.
- `buf_in_commit_len` out 10: committed length in bytes, equal to len+1.
- `buf_in_commit_ack` in 1: asynchronous, 2-flop synchronised; the rising edge of the synced signal is used.

## Operation
- Reset values: all outputs 0, `state`=IDLE, `last`=1 (so ch0 wins the first tie), byte counter 0, timeout counter 0.
- Arbitration is round-robin. If only one `reqN` is high, grant it. If both are high, grant the channel ≠ `last`. On grant, latch `chan`, `len` and `last<=chan`.
- States:
  - IDLE: if any req, latch grant and go to WAIT_RDY.
  - WAIT_RDY: stay until `ready_s`=1, then go to HDR.
  - HDR: `buf_in_addr`<=0, `buf_in_data`<=`HDR_BASE|chan`, go to WR.
  - WR: `buf_in_wren`<=1, go to WRX.
  - WRX: `buf_in_wren`<=0. If remaining count = 0, go to COMMIT. Otherwise go to RD.
  - RD: `rdN`<=1 for the granted channel only, go to LAT.
  - LAT: `rdN`<=0, go to CAP.
  - CAP: `buf_in_data`<=`datN`, `buf_in_addr`<=`buf_in_addr`+1, remaining−1, go to WR.
  - COMMIT: `buf_in_commit`<=1 for one cycle, `buf_in_commit_len`<={1'b0,len}+1, clear the timeout counter, go to WAIT_ACK.
  - WAIT_ACK: on the ack_s rising edge, pulse `doneN` and go to IDLE. When the timeout counter reaches `ACK_TIMEOUT`, pulse `errN` and go to IDLE.
- Width rules:
  - Address is 9 bits; the max packet (header + 511 bytes) ends at address 511, with no wrap.
  - Commit length is 10 bits, range 1..512.
  - `len`=0 sends the header only, with commit_len=1.
- The `reqN` input of the granted channel is not re-sampled mid-packet. Dropping it does not abort the packet.
- The non-granted channel's `rd`, `done` and `err` stay 0 throughout.
- `buf_in_ready` is checked only in WAIT_RDY. Deasserting it mid-packet has no effect.

## Timing
- Synchroniser latency for ready/ack: 2 cycles from the pin to `ready_s`/`ack_s`, plus 1 cycle to detect the ack edge.
- If `req` is high and `ready_s` is already 1:
  - Grant is latched on the first edge, when IDLE→WAIT_RDY.
  - HDR occurs 2 cycles after the req sample.
  - The header `wren` pulse occurs 3 cycles after the req sample.
- Each payload byte takes 5 cycles (RD, LAT, CAP, WR, WRX). `wren` is high exactly 1 cycle per byte, and addr/data are stable during it.
- Commit pulse: 1 cycle after the final WRX. Total from the IDLE sample to the commit pulse is 6+5·len cycles.
- A new grant can occur at the earliest 1 cycle after `doneN`/`errN`, from IDLE.
- Simultaneous events:
  - Ack edge and timeout on the same cycle: ack wins and `doneN` pulses.
  - `reset` with anything: reset wins.
- Reset mid-packet: the next edge returns all outputs to 0 and state to IDLE. No commit, `done` or `err` is issued. The partial buffer contents are ignored.

## Test plan
- Ch0 only, len0=3, dat=11,22,33, ready=1, ack returned 5 cycles after commit:
  - Writes at addr0..3 are A0,11,22,33, each with a 1-cycle `wren`.
  - Commit_len=4, 6+15 cycles after the IDLE sample.
  - One `done0` pulse and no `rd1`.
- req0 and req1 held continuously, both len=1:
  - Grant order is ch0, ch1, ch0, ch1.
  - Headers alternate A0/A1.
- len1=0: a single write, A1 at addr0, then commit_len=1, then `done1`.
- len0=511:
  - The last write is at addr 511.
  - Commit_len=512.
  - No address wrap and exactly 511 `rd0` pulses.
- Ack never returned, ACK_TIMEOUT=20:
  - `err0` pulses 20 cycles after entering WAIT_ACK.
  - The arbiter then serves a pending req1.
- ready held 0 for 50 cycles, then 1: no writes or `rd` until 2 cycles after ready rises.
- Reset mid-packet: reset asserted during byte 2 of len=5; all outputs are 0 next cycle, with no commit or `done`.
